// File: rtl/text_row_renderer_pkg.sv
// Shared font geometry and character codes for the text row renderer and the
// producers that write readouts into its character buffer.
package text_pkg;

    localparam int GLYPH_W_DEF = 16;
    localparam int GLYPH_H_DEF = 32;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_PCT   = 8'h25;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_F     = 8'h46;
    localparam logic [7:0] CH_H     = 8'h48;
    localparam logic [7:0] BLINK_ATTR = 8'h80;

    // Non-BCD nibbles come out as '-' so a bad reading is obvious on screen.
    function automatic logic [7:0] ascii_digit(input logic [3:0] bcd);
        return (bcd <= 4'd9) ? (CH_ZERO + {4'd0, bcd}) : CH_MINUS;
    endfunction

endpackage

// File: rtl/text_row_renderer_glyph_rom.sv
// 16x32 font ROM: one row of glyph pixels per lookup, column 0 in the MSB.
// Digits and C/F/H share a seven-segment layout; unknown codes draw a hollow box.
module glyph_rom16x32
    import text_pkg::*;
(
    input  logic [6:0]  i_code,
    input  logic [4:0]  i_row,
    output logic [15:0] o_bits
);

    localparam logic [15:0] SEG_L   = 16'h1800;
    localparam logic [15:0] SEG_R   = 16'h0018;
    localparam logic [15:0] SEG_BAR = 16'h1FF8;

    // s = {a,b,c,d,e,f,g}
    function automatic logic [15:0] seg_row(input logic [6:0] s, input logic [4:0] r);
        logic [15:0] v;
        v = '0;
        if (r >= 5'd4 && r <= 5'd5)        v = s[6] ? SEG_BAR : '0;
        else if (r >= 5'd6 && r <= 5'd14)  v = (s[1] ? SEG_L : '0) | (s[5] ? SEG_R : '0);
        else if (r >= 5'd15 && r <= 5'd16) v = s[0] ? SEG_BAR :
            (((s[1] | s[2]) ? SEG_L : '0) | ((s[5] | s[4]) ? SEG_R : '0));
        else if (r >= 5'd17 && r <= 5'd25) v = (s[2] ? SEG_L : '0) | (s[4] ? SEG_R : '0);
        else if (r >= 5'd26 && r <= 5'd27) v = s[3] ? SEG_BAR : '0;
        return v;
    endfunction

    logic       w_blank;
    logic [4:0] w_rm4;
    logic [3:0] w_diag;

    assign w_blank = (i_row < 5'd4) || (i_row > 5'd27);
    assign w_rm4   = i_row - 5'd4;
    assign w_diag  = w_rm4[4:1];

    always_comb begin
        o_bits = '0;
        case (i_code)
            CH_SPACE[6:0]: o_bits = '0;
            7'h30: o_bits = seg_row(7'b1111110, i_row);
            7'h31: o_bits = seg_row(7'b0110000, i_row);
            7'h32: o_bits = seg_row(7'b1101101, i_row);
            7'h33: o_bits = seg_row(7'b1111001, i_row);
            7'h34: o_bits = seg_row(7'b0110011, i_row);
            7'h35: o_bits = seg_row(7'b1011011, i_row);
            7'h36: o_bits = seg_row(7'b1011111, i_row);
            7'h37: o_bits = seg_row(7'b1110000, i_row);
            7'h38: o_bits = seg_row(7'b1111111, i_row);
            7'h39: o_bits = seg_row(7'b1111011, i_row);
            CH_C[6:0]: o_bits = seg_row(7'b1001110, i_row);
            CH_F[6:0]: o_bits = seg_row(7'b1000111, i_row);
            CH_H[6:0]: o_bits = seg_row(7'b0110111, i_row);
            CH_MINUS[6:0]: o_bits = (i_row == 5'd15 || i_row == 5'd16) ? SEG_BAR : '0;
            CH_DOT[6:0]:   o_bits = (i_row >= 5'd24 && i_row <= 5'd27) ? 16'h0180 : '0;
            CH_COLON[6:0]: o_bits = ((i_row >= 5'd9 && i_row <= 5'd11) ||
                                     (i_row >= 5'd20 && i_row <= 5'd22)) ? 16'h0180 : '0;
            CH_PCT[6:0]: begin
                // diagonal walks from column 12 at the top to column 1 at the bottom
                if (!w_blank) begin
                    o_bits = 16'h8000 >> (4'd12 - w_diag);
                    if (i_row >= 5'd5 && i_row <= 5'd7)   o_bits = o_bits | 16'h3000;
                    if (i_row >= 5'd24 && i_row <= 5'd26) o_bits = o_bits | 16'h000C;
                end
            end
            default: begin
                if (!w_blank)
                    o_bits = (i_row == 5'd4 || i_row == 5'd27) ? 16'hFFFF : 16'h8001;
            end
        endcase
    end

endmodule

// File: rtl/text_row_renderer.sv
// Two-stage pixel pipeline drawing one row of NUM_CHARS scaled glyphs from a
// writable character buffer, with a frame-counted blink attribute.
module text_row_renderer
    import text_pkg::*;
#(
    parameter int NUM_CHARS    = 8,
    parameter int GLYPH_W      = GLYPH_W_DEF,
    parameter int GLYPH_H      = GLYPH_H_DEF,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       pix_valid,
    input  logic       frame_tick,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    output logic       on_text,
    output logic       text_valid
);

    localparam int COL_W   = $clog2(GLYPH_W);
    localparam int ROW_W   = $clog2(GLYPH_H);
    localparam int CW_LOG2 = COL_W + SCALE_LOG2;
    localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [10:0]      BOX_W    = 11'(NUM_CHARS << CW_LOG2);
    localparam logic [10:0]      BOX_H    = 11'(GLYPH_H << SCALE_LOG2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [1:0]                 r_rst_sync;
    logic                       w_rst_n;
    logic [NUM_CHARS-1:0][7:0]  r_buf;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_phase;
    logic [1:0]                 r_vld_pipe;
    logic                       r_in_box;
    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic [7:0]                 r_char;
    logic                       r_on_text;

    logic [9:0]       w_rel_x, w_rel_y, w_cell;
    logic             w_in_box;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [7:0]       w_char;
    logic [15:0]      w_row_bits;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_rel_x  = x - start_x;
    assign w_rel_y  = y - start_y;
    assign w_in_box = ({1'b0, x} >= {1'b0, start_x}) && ({1'b0, x} < {1'b0, start_x} + BOX_W) &&
                      ({1'b0, y} >= {1'b0, start_y}) && ({1'b0, y} < {1'b0, start_y} + BOX_H);
    assign w_cell   = w_rel_x >> CW_LOG2;
    assign w_col    = COL_W'(w_rel_x >> SCALE_LOG2);
    assign w_row    = ROW_W'(w_rel_y >> SCALE_LOG2);

    // Cells past the row only occur outside the box, where the char is don't-care.
    always_comb begin
        w_char = CH_SPACE;
        for (int i = 0; i < NUM_CHARS; i++)
            if (w_cell == 10'(i)) w_char = r_buf[i];
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) r_buf[i] <= CH_SPACE;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CHARS; i++)
                if (wr_addr == 5'(i)) r_buf[i] <= wr_char;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (frame_tick) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    glyph_rom16x32 u_rom (
        .i_code (r_char[6:0]),
        .i_row  (r_row),
        .o_bits (w_row_bits)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vld_pipe <= '0;
            r_in_box   <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_char     <= '0;
            r_on_text  <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], pix_valid};
            r_in_box   <= w_in_box;
            r_col      <= w_col;
            r_row      <= w_row;
            r_char     <= w_char;
            r_on_text  <= r_vld_pipe[0] && r_in_box && w_row_bits[~r_col] &&
                          !(r_char[7] && r_phase);
        end
    end

    assign on_text    = r_on_text;
    assign text_valid = r_vld_pipe[1];

endmodule

// File: tb/tb_text_row_renderer.sv
// Scoreboard bench: three renderer configurations share one stimulus stream and
// each is compared pixel by pixel against a small behavioural model.
module tb_text_row_renderer;
    import text_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] start_x = 10'd100, start_y = 10'd50, x = '0, y = '0;
    logic       pix_valid = 1'b0, frame_tick = 1'b0, wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_char = '0;
    logic       on_a, tv_a, on_b, tv_b, on_c, tv_c;

    int n_chk = 0, n_fail = 0;
    bit qa[$], qb[$], qc[$];
    logic [7:0] mbuf [8];
    bit mphase = 1'b0;
    int mcnt = 0;

    always #5 clk = ~clk;

    text_row_renderer #(.NUM_CHARS(8), .SCALE_LOG2(0), .BLINK_FRAMES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start_x(start_x), .start_y(start_y), .x(x), .y(y),
        .pix_valid(pix_valid), .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .on_text(on_a), .text_valid(tv_a));
    text_row_renderer #(.NUM_CHARS(8), .SCALE_LOG2(1), .BLINK_FRAMES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start_x(start_x), .start_y(start_y), .x(x), .y(y),
        .pix_valid(pix_valid), .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .on_text(on_b), .text_valid(tv_b));
    text_row_renderer #(.NUM_CHARS(1), .SCALE_LOG2(0), .BLINK_FRAMES(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .start_x(start_x), .start_y(start_y), .x(x), .y(y),
        .pix_valid(pix_valid), .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .on_text(on_c), .text_valid(tv_c));

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference font rows for the codes this bench writes.
    function automatic logic [15:0] g_row(input logic [6:0] c, input int r);
        if (r < 4 || r > 27) return 16'h0000;
        case (c)
            7'h20: return 16'h0000;
            7'h30: return (r <= 5 || r >= 26) ? 16'h1FF8 : 16'h1818;
            7'h31: return (r <= 5 || r >= 26) ? 16'h0000 : 16'h0018;
            7'h2D: return (r == 15 || r == 16) ? 16'h1FF8 : 16'h0000;
            default: return (r == 4 || r == 27) ? 16'hFFFF : 16'h8001;
        endcase
    endfunction

    function automatic bit exp_pix(input int scale, input int nch, input int px, input int py);
        int cw, sx, sy, rx, col, row;
        logic [7:0]  ch;
        logic [15:0] bits;
        cw = 16 << scale;
        sx = int'(start_x);
        sy = int'(start_y);
        if (px < sx || px >= sx + nch * cw || py < sy || py >= sy + (32 << scale)) return 1'b0;
        rx  = px - sx;
        ch  = mbuf[rx / cw];
        col = (rx % cw) >> scale;
        row = (py - sy) >> scale;
        if (ch[7] && mphase) return 1'b0;
        bits = g_row(ch[6:0], row);
        return bits[15 - col];
    endfunction

    task automatic cyc(input logic pv, input int px, input int py, input logic we,
                       input logic [4:0] wa, input logic [7:0] wc, input logic ft);
        x = 10'(px); y = 10'(py); pix_valid = pv;
        wr_en = we; wr_addr = wa; wr_char = wc; frame_tick = ft;
        if (pv) begin
            qa.push_back(exp_pix(0, 8, px, py));
            qb.push_back(exp_pix(1, 8, px, py));
            qc.push_back(exp_pix(0, 1, px, py));
        end
        if (we && wa < 5'd8) mbuf[wa] = wc;
        if (ft) begin
            if (mcnt == 1) begin mcnt = 0; mphase = ~mphase; end
            else mcnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();                                  cyc(0, 0, 0, 0, 5'd0, 8'h00, 0); endtask
    task automatic wr(input logic [4:0] a, input logic [7:0] c); cyc(0, 0, 0, 1, a, c, 0);       endtask
    task automatic tick();                                  cyc(0, 0, 0, 0, 5'd0, 8'h00, 1); endtask
    task automatic scan(input int py, input int x0, input int x1);
        for (int i = x0; i <= x1; i++) cyc(1, i, py, 0, 5'd0, 8'h00, 0);
        repeat (3) idle();
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (tv_a) begin
                chk("a_qnonempty", 16'(qa.size() > 0), 16'd1);
                if (qa.size() > 0) chk("a_on", 16'(on_a), 16'(qa.pop_front()));
            end
            if (tv_b) begin
                chk("b_qnonempty", 16'(qb.size() > 0), 16'd1);
                if (qb.size() > 0) chk("b_on", 16'(on_b), 16'(qb.pop_front()));
            end
            if (tv_c) begin
                chk("c_qnonempty", 16'(qc.size() > 0), 16'd1);
                if (qc.size() > 0) chk("c_on", 16'(on_c), 16'(qc.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) mbuf[i] = CH_SPACE;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) idle();

        // digit '0' in cell 0, then the blank top row of the glyph
        wr(5'd0, 8'h30);
        scan(54, 96, 120);
        scan(50, 100, 115);

        // reset in the middle of a scan
        for (int i = 104; i <= 110; i++) cyc(1, i, 54, 0, 5'd0, 8'h00, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_on_a", 16'(on_a), 16'd0); chk("rst_tv_a", 16'(tv_a), 16'd0);
        chk("rst_on_b", 16'(on_b), 16'd0); chk("rst_tv_b", 16'(tv_b), 16'd0);
        chk("rst_on_c", 16'(on_c), 16'd0); chk("rst_tv_c", 16'(tv_c), 16'd0);
        qa.delete(); qb.delete(); qc.delete();
        for (int i = 0; i < 8; i++) mbuf[i] = CH_SPACE;
        mphase = 1'b0; mcnt = 0;
        pix_valid = 1'b0; wr_en = 1'b0; frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) idle();
        scan(54, 96, 240);

        // scaled '-' glyphs and the right edge of the scaled box
        wr(5'd0, CH_MINUS); wr(5'd1, 8'h30); wr(5'd7, CH_MINUS);
        scan(80, 96, 140);
        scan(79, 100, 104);
        scan(81, 100, 104);
        scan(84, 100, 104);
        scan(80, 340, 360);

        // write collision on cell 2, then an out-of-range write
        wr(5'd2, 8'h41);
        for (int i = 128; i <= 131; i++) cyc(1, i, 60, 0, 5'd0, 8'h00, 0);
        cyc(1, 132, 60, 1, 5'd2, 8'h31, 0);
        scan(60, 133, 148);
        wr(5'd31, 8'h41);
        scan(60, 128, 148);

        // blink: two ticks per phase
        wr(5'd0, 8'hB0); wr(5'd1, 8'h30);
        scan(54, 100, 131);
        tick(); idle(); tick(); idle();
        scan(54, 100, 131);
        tick(); idle(); tick(); idle();
        scan(54, 100, 131);

        // right screen edge with no wrap, and an unknown code
        start_x = 10'd1008;
        wr(5'd0, 8'h41);
        scan(54, 1000, 1023);
        scan(60, 1000, 1023);
        scan(54, 0, 7);
        scan(60, 0, 7);

        repeat (4) idle();
        chk("a_drain", 16'(qa.size()), 16'd0);
        chk("b_drain", 16'(qb.size()), 16'd0);
        chk("c_drain", 16'(qc.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
